muldiv_unit: RTL and testbench

//   Parametrised iterative multiply/divide unit for the multicycle datapath; replaces separate mult/div blocks.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_signfix.sv | 12 +
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op and state encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational conditional two's-complement negate of a W-bit value.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide into HI/LO.
// MULDIV_EARLY_EXIT_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               div_r, sgn_a, sgn_b, dz;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;   // multiplier, or dividend shifting into quotient
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH:0]     rem;

  logic               accept, a_neg, b_neg, b_zero, last_iter, rem_ge;
  logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH+1:0]   rem_sh, rem_diff;

  // The done cycle is IDLE, but a start there must still be dropped.
  assign accept = (state == S_IDLE) && start && !done;
  assign a_neg  = op_is_signed(op) & a[WIDTH-1];
  assign b_neg  = op_is_signed(op) & b[WIDTH-1];
  assign b_zero = op_is_div(op) && (b == '0);
  assign busy   = (state != S_IDLE);

  muldiv_signfix #(.W(WIDTH))   u_abs_a (.neg(a_neg),         .din(a),              .dout(abs_a));
  muldiv_signfix #(.W(WIDTH))   u_abs_b (.neg(b_neg),         .din(b),              .dout(abs_b));
  muldiv_signfix #(.W(2*WIDTH)) u_prod  (.neg(sgn_a ^ sgn_b), .din(acc),            .dout(prod_fix));
  muldiv_signfix #(.W(WIDTH))   u_quo   (.neg(sgn_a ^ sgn_b), .din(mplier),         .dout(quo_fix));
  muldiv_signfix #(.W(WIDTH))   u_rem   (.neg(sgn_a),         .din(rem[WIDTH-1:0]), .dout(rem_fix));

  // Restoring step: the sign of the trial subtraction decides the quotient bit.
  assign rem_sh   = {rem, mplier[WIDTH-1]};
  assign rem_diff = rem_sh - {2'b00, divisor};
  assign rem_ge   = ~rem_diff[WIDTH+1];

`ifdef MULDIV_EARLY_EXIT_EN
  assign last_iter = (cnt == CNT_W'(1)) || (!div_r && (mplier[WIDTH-1:1] == '0));
`else
  assign last_iter = (cnt == CNT_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = b_zero ? S_FIN : S_RUN;
      S_RUN:   if (last_iter) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      done    <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      div_r   <= 1'b0;
      sgn_a   <= 1'b0;
      sgn_b   <= 1'b0;
      dz      <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      divisor <= '0;
      rem     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            div_r   <= op_is_div(op);
            sgn_a   <= a_neg;
            sgn_b   <= b_neg;
            dz      <= b_zero;
            div0    <= 1'b0;
            cnt     <= CNT_W'(WIDTH);
            acc     <= '0;
            rem     <= '0;
            mcand   <= {{WIDTH{1'b0}}, abs_a};
            mplier  <= op_is_div(op) ? abs_a : abs_b;
            divisor <= abs_b;
          end
        end
        S_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (div_r) begin
            rem    <= rem_ge ? rem_diff[WIDTH:0] : rem_sh[WIDTH:0];
            mplier <= {mplier[WIDTH-2:0], rem_ge};
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        S_FIN: begin
          done <= 1'b1;
          div0 <= dz;
          if (!dz) begin
            if (div_r) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, hand sequences, random vs arithmetic model.
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic [1:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, div0;
  logic [W-1:0]  hi, lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  int n_pass = 0;
  int n_tot  = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [31:0] a, b, hi, lo;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected done latency from the arithmetic view of the operation.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] bb);
    logic [31:0] mag;
    int top;
    if (o[1]) return (bb == 0) ? 1 : 33;
    if (!EARLY) return 33;
    mag = (o == 2'b00 && bb[31]) ? (32'd0 - bb) : bb;
    top = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) top = i + 1;
    return top + 1;
  endfunction

  task automatic ref_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    edz = 1'b0;
    case (o)
      2'b00: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
      2'b01: begin p = {32'd0, aa} * {32'd0, bb}; {m_hi, m_lo} = p; end
      2'b10: if (bb == 0) edz = 1'b1;
             else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      default: if (bb == 0) edz = 1'b1;
               else begin m_lo = aa / bb; m_hi = aa % bb; end
    endcase
    ehi = m_hi;
    elo = m_lo;
  endtask

  // Issue one op, scramble operands afterwards, optionally poke start mid-run.
  task automatic do_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb, input int poke,
                       output logic [31:0] ghi, output logic [31:0] glo, output logic gdz,
                       output int glat, output logic gdone_after);
    @(negedge clk);
    start = 1'b1; op = o; a = aa; b = bb;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    glat = -1; ghi = 'x; glo = 'x; gdz = 1'bx;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == poke) begin start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd0; end
      if (done) begin
        ghi = hi; glo = lo; gdz = div0; glat = k;
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    gdone_after = done;
  endtask

  task automatic run_vec(input vec_t v, input int poke);
    logic [31:0] ghi, glo, mhi, mlo;
    logic gdz, mdz, gda;
    int glat;
    ref_op(v.op, v.a, v.b, mhi, mlo, mdz);
    do_op(v.op, v.a, v.b, poke, ghi, glo, gdz, glat, gda);
    check({v.name, " hi"},   64'(ghi), 64'(v.hi));
    check({v.name, " lo"},   64'(glo), 64'(v.lo));
    check({v.name, " div0"}, 64'(gdz), 64'(v.dz));
    check({v.name, " lat"},  64'(glat), 64'(v.lat));
    check({v.name, " done pulse"}, 64'(gda), 64'd0);
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    tbl.push_back('{"divu 20/4",  2'b11, 32'd20, 32'd4, 32'd0, 32'd5, 1'b0, 33});
    tbl.push_back('{"div 23/7",   2'b10, 32'd23, 32'd7, 32'd2, 32'd3, 1'b0, 33});
    tbl.push_back('{"div -7/2",   2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33});
    tbl.push_back('{"div 10/0",   2'b10, 32'd10, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1});
    tbl.push_back('{"mult -5*3",  2'b00, 32'hFFFFFFFB, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, EARLY ? 3 : 33});
    tbl.push_back('{"multu max*2", 2'b01, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 1'b0, EARLY ? 3 : 33});
    tbl.push_back('{"mult 2^16*2^16", 2'b00, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 1'b0, EARLY ? 18 : 33});
    tbl.push_back('{"div minneg/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33});
    tbl.push_back('{"multu 6*1",  2'b01, 32'd6, 32'd1, 32'd0, 32'd6, 1'b0, EARLY ? 2 : 33});

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div0", 64'(div0), 64'd0);
    check("reset hi",   64'(hi),   64'd0);
    check("reset lo",   64'(lo),   64'd0);

    foreach (tbl[i]) run_vec(tbl[i], 0);

    // Start pulsed mid-run must not disturb the running multiply.
    rv = '{"multu mid-start", 2'b01, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0, exp_lat(2'b01, 32'd9)};
    run_vec(rv, 1);

    // Divide by zero, then a start in the done cycle is dropped, then a real start clears div0.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("dz done", 64'(done), 64'd1);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("start in done cycle busy", 64'(busy), 64'd0);
    check("div0 held", 64'(div0), 64'd1);
    check("hi kept after dz", 64'(hi), 64'(m_hi));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("div0 cleared on start", 64'(div0), 64'd0);
    check("busy after start", 64'(busy), 64'd1);
    begin
      int lat = -1;
      for (int k = 1; k <= 100; k++) begin
        @(negedge clk);
        if (done) begin lat = k; break; end
      end
      check("multu 3*3 lat", 64'(lat), 64'(exp_lat(2'b01, 32'd3)));
      check("multu 3*3 lo", 64'(lo), 64'd9);
      m_hi = 32'd0; m_lo = 32'd9;
    end

    // Reset during RUN aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy in run", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("abort no done", 64'(seen), 64'd0);
    end

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      vec_t v;
      logic [31:0] ehi, elo;
      logic edz;
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      v.name = $sformatf("rand%0d op%0d %h/%h", i, ro, ra, rb);
      v.op = ro; v.a = ra; v.b = rb;
      v.lat = exp_lat(ro, rb);
      begin
        logic [31:0] sh, sl;
        sh = m_hi; sl = m_lo;
        ref_op(ro, ra, rb, ehi, elo, edz);
        m_hi = sh; m_lo = sl;
      end
      v.hi = ehi; v.lo = elo; v.dz = edz;
      run_vec(v, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
